// File: rtl/pb_preload_pkg.sv
// Shared types for the picobello preload write-port arbiter.
// Holds FSM/boot-mode enums, the requester index type and the boot-mode eligibility rule.
package pb_preload_pkg;

    localparam int unsigned NumReqDefault = 4;
    localparam int unsigned SrcWidth      = $clog2(NumReqDefault);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        BootIdle = 2'd0,
        BootSd   = 2'd1,
        BootSpi  = 2'd2,
        BootI2c  = 2'd3
    } boot_mode_e;

    typedef logic [SrcWidth-1:0] src_idx_t;

    // Autonomous/SD boot leaves only JTAG (index 0) able to preload.
    function automatic logic req_eligible(boot_mode_e mode, int unsigned idx);
        return (mode == BootIdle) || (idx == 0);
    endfunction

endpackage

// File: rtl/pb_preload_arb_if.sv
// Preload requester bundle plus the single memory-side write channel.
// slave is the arbiter's view; master is the view of whatever drives requests and sinks beats.
interface pb_preload_arb_if #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64
);
    localparam int unsigned SrcW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]                req_valid_i;
    logic [NumReq-1:0][AddrWidth-1:0] req_addr_i;
    logic [NumReq-1:0][DataWidth-1:0] req_data_i;
    logic [NumReq-1:0]                req_last_i;
    logic [NumReq-1:0]                req_ready_o;

    logic                 mem_valid_o;
    logic                 mem_ready_i;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0] mem_data_o;
    logic                 mem_last_o;
    logic [SrcW-1:0]      mem_src_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_last_i, mem_ready_i,
        output req_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_last_o, mem_src_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_last_i, mem_ready_i,
        input  req_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_last_o, mem_src_o
    );

endinterface

// File: rtl/pb_preload_rr_pick.sv
// Masked round-robin pick: first index at or after ptr (wrapping) that is both
// eligible and valid.
module pb_preload_rr_pick #(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] mask,
    input  logic [NumReq-1:0] valid,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   idx,
    output logic              found
);

    always_comb begin
        int unsigned cand;
        logic [IdxW-1:0] cand_idx;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand     = (32'(ptr) + k) % NumReq;
            cand_idx = IdxW'(cand);
            if (!found && mask[cand_idx] && valid[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/pb_preload_arb.sv
// Shared preload write-port arbiter: round-robin burst grant, boot-mode masking,
// combinational beat pass-through while a burst is granted, and runaway-burst guard.
module pb_preload_arb
    import pb_preload_pkg::*;
#(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned MaxBurst  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            boot_mode_i,
    input  logic                  err_clr_i,
    output logic                  busy_o,
    output logic                  err_o,
    pb_preload_arb_if.slave       bus
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(MaxBurst + 1);

    arb_state_e        state;
    logic [IdxW-1:0]   gnt;
    logic [IdxW-1:0]   rr_ptr;
    logic [IdxW-1:0]   next_ptr;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_found;
    logic [CntW-1:0]   beat_cnt;
    logic [NumReq-1:0] elig;
    logic              gnt_valid;
    logic              gnt_last;
    logic              at_limit;
    logic              beat_hs;
    logic              burst_end;
    logic              overflow;

    // Boot mode only matters when a new grant is picked, i.e. in IDLE.
    always_comb begin
        elig = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            elig[k] = req_eligible(boot_mode_e'(boot_mode_i), k);
        end
    end

    pb_preload_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .mask  (elig),
        .valid (bus.req_valid_i),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign gnt_valid = bus.req_valid_i[gnt];
    assign gnt_last  = bus.req_last_i[gnt];
    assign at_limit  = (beat_cnt == CntW'(MaxBurst - 1));
    assign beat_hs   = (state == BUSY) && gnt_valid && bus.mem_ready_i;
    assign burst_end = gnt_last || at_limit;
    assign overflow  = beat_hs && at_limit && !gnt_last;
    assign next_ptr  = (gnt == IdxW'(NumReq - 1)) ? '0 : gnt + IdxW'(1);
    assign busy_o    = (state == BUSY);

    // Zero-latency pass-through of the granted requester; payload is zeroed when no beat is offered.
    always_comb begin
        bus.mem_valid_o = (state == BUSY) && gnt_valid;
        bus.req_ready_o = '0;
        bus.mem_addr_o  = '0;
        bus.mem_data_o  = '0;
        bus.mem_last_o  = 1'b0;
        bus.mem_src_o   = '0;
        if (state == BUSY) begin
            bus.req_ready_o[gnt] = bus.mem_ready_i;
        end
        if (bus.mem_valid_o) begin
            bus.mem_addr_o = bus.req_addr_i[gnt];
            bus.mem_data_o = bus.req_data_i[gnt];
            bus.mem_last_o = burst_end;
            bus.mem_src_o  = gnt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt      <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // A forced last (beat limit) closes the burst like a real one.
                    if (beat_hs) begin
                        if (burst_end) begin
                            state    <= IDLE;
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CntW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (overflow) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pb_preload_arb.sv
// Scoreboard bench for pb_preload_arb: directed scenarios plus random multi-requester rounds,
// with expected beat order computed by a transaction-level round-robin model.
module tb_pb_preload_arb;
    import pb_preload_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 64;
    localparam int unsigned MB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] boot_mode = 2'd0;
    logic       err_clr = 1'b0;
    logic       busy;
    logic       err;

    pb_preload_arb_if #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW)) bus ();

    pb_preload_arb #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxBurst(MB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .boot_mode_i (boot_mode),
        .err_clr_i   (err_clr),
        .busy_o      (busy),
        .err_o       (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        src_idx_t      src;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    beat_t       srcq [NR][$];
    beat_t       mq   [NR][$];
    exp_t        expq [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          beats_seen = 0;
    int          last_hs_cyc = 0;
    logic [NR-1:0] hs_mask = '0;
    int          chunk_pos [NR];
    int          ready_mode = 0;   // 0 always, 1 toggle, 2 random, 3 never
    bit          gap_en = 1'b0;
    int          mptr = 0;
    bit          model_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic add_burst(input int r, input int n, input logic [AW-1:0] base, input bit with_last);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.addr = base + AW'(8 * k);
            b.data = {$urandom, $urandom};
            b.last = with_last && (k == n - 1);
            srcq[r].push_back(b);
            mq[r].push_back(b);
        end
    endtask

    // Reference: repeatedly serve the first eligible requester with queued beats at/after the
    // pointer, one burst (or one MB-beat slice) at a time, then move the pointer past it.
    task automatic model_run(input logic [NR-1:0] elig);
        int    pick;
        int    n;
        bit    done;
        beat_t b;
        exp_t  e;
        while (1) begin
            pick = -1;
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (mptr + k) % NR;
                if (pick < 0 && elig[c] && mq[c].size() > 0) pick = c;
            end
            if (pick < 0) break;
            n = 0;
            done = 1'b0;
            while (!done && mq[pick].size() > 0) begin
                b = mq[pick].pop_front();
                n++;
                e.src  = src_idx_t'(pick);
                e.addr = b.addr;
                e.data = b.data;
                e.last = b.last || (n == MB);
                if (n == MB && !b.last) model_err = 1'b1;
                expq.push_back(e);
                done = e.last;
            end
            mptr = (pick + 1) % NR;
        end
    endtask

    task automatic wait_drain(input int budget);
        int  n = 0;
        bit  empty;
        while (1) begin
            empty = (expq.size() == 0);
            for (int i = 0; i < NR; i++) if (srcq[i].size() != 0) empty = 1'b0;
            if (empty || n >= budget) break;
            @(negedge clk); #1;
            n++;
        end
        if (!empty) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", expq.size());
        end
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (beats_seen < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (beats_seen < target) begin
            checks++;
            errors++;
            $display("FAIL wait_beats: got %0d beats, expected %0d", beats_seen, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_valid"}, 128'(bus.mem_valid_o), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_req_ready"}, 128'(bus.req_ready_o), 128'(0));
        chk({tag, "_payload"}, 128'({bus.mem_addr_o, bus.mem_data_o, bus.mem_last_o, bus.mem_src_o}), 128'(0));
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk); #1;
        err_clr = 1'b0;
        chk("err_cleared", 128'(err), 128'(0));
    endtask

    // Requester/memory-side driver: updates just after each rising edge.
    initial begin
        logic [NR-1:0] stalled;
        beat_t         b;
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        bus.req_last_i  = '0;
        bus.mem_ready_i = 1'b0;
        for (int i = 0; i < NR; i++) chunk_pos[i] = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                for (int i = 0; i < NR; i++) begin
                    srcq[i].delete();
                    chunk_pos[i] = 0;
                end
                bus.req_valid_i = '0;
                bus.mem_ready_i = 1'b0;
                continue;
            end
            stalled = bus.req_valid_i & ~hs_mask;
            for (int i = 0; i < NR; i++) begin
                if (hs_mask[i] && srcq[i].size() > 0) begin
                    b = srcq[i].pop_front();
                    chunk_pos[i]++;
                    if (b.last || chunk_pos[i] == MB) chunk_pos[i] = 0;
                end
                if (srcq[i].size() == 0) begin
                    bus.req_valid_i[i] = 1'b0;
                    bus.req_addr_i[i]  = '0;
                    bus.req_data_i[i]  = '0;
                    bus.req_last_i[i]  = 1'b0;
                end else begin
                    b = srcq[i][0];
                    bus.req_addr_i[i] = b.addr;
                    bus.req_data_i[i] = b.data;
                    bus.req_last_i[i] = b.last;
                    if (stalled[i]) bus.req_valid_i[i] = 1'b1;
                    else if (gap_en && chunk_pos[i] > 0 && $urandom_range(0, 3) == 0) bus.req_valid_i[i] = 1'b0;
                    else bus.req_valid_i[i] = 1'b1;
                end
            end
            case (ready_mode)
                0:       bus.mem_ready_i = 1'b1;
                1:       bus.mem_ready_i = ~bus.mem_ready_i;
                2:       bus.mem_ready_i = 1'($urandom_range(0, 1));
                default: bus.mem_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: samples on the falling edge and checks each offered beat against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            hs_mask = bus.req_valid_i & bus.req_ready_o;
            if (rst) continue;
            if (bus.mem_valid_o) begin
                chk("busy_in_burst", 128'(busy), 128'(1));
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got src=%0d addr=%0h, expected no beat", bus.mem_src_o, bus.mem_addr_o);
                end else begin
                    e = expq[0];
                    chk("mem_src", 128'(bus.mem_src_o), 128'(e.src));
                    chk("mem_addr", 128'(bus.mem_addr_o), 128'(e.addr));
                    chk("mem_data", 128'(bus.mem_data_o), 128'(e.data));
                    chk("mem_last", 128'(bus.mem_last_o), 128'(e.last));
                    chk("req_ready_mirror", 128'(bus.req_ready_o),
                        128'(bus.mem_ready_i ? (NR'(1) << e.src) : NR'(0)));
                    if (bus.mem_ready_i) begin
                        void'(expq.pop_front());
                        beats_seen++;
                        last_hs_cyc = cyc;
                    end
                end
            end else begin
                chk("idle_payload", 128'({bus.mem_addr_o, bus.mem_data_o, bus.mem_last_o, bus.mem_src_o}), 128'(0));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int push_cyc;
        int base;
        int nb;
        bit any;

        // Reset values, then quiet operation after release.
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("quiet_mem_valid", 128'(bus.mem_valid_o), 128'(0));
            chk("quiet_busy", 128'(busy), 128'(0));
        end

        // Contention: four 2-beat bursts from pointer 0.
        for (int i = 0; i < NR; i++) add_burst(i, 2, AW'(48'h1000_0000 + 48'h100 * i), 1'b1);
        push_cyc = cyc;
        model_run('1);
        wait_drain(200);
        chk("contention_cycles", 128'(last_hs_cyc - push_cyc), 128'(12));

        // Single JTAG burst.
        add_burst(0, 4, AW'(48'h7000_0000), 1'b1);
        model_run('1);
        wait_drain(200);
        chk("jtag_idle_after", 128'(busy), 128'(0));

        // Backpressure with alternating memory ready.
        ready_mode = 1;
        add_burst(3, 4, AW'(48'h2000_0000), 1'b1);
        model_run('1);
        wait_drain(200);
        ready_mode = 0;

        // Boot-mode masking, then mode change mid-burst.
        boot_mode = 2'd2;
        base = beats_seen;
        add_burst(1, 2, AW'(48'h3000_0000), 1'b1);
        add_burst(2, 2, AW'(48'h3100_0000), 1'b1);
        repeat (8) @(negedge clk);
        #1;
        chk("masked_busy", 128'(busy), 128'(0));
        chk("masked_no_beats", 128'(beats_seen - base), 128'(0));
        add_burst(0, 4, AW'(48'h7100_0000), 1'b1);
        model_run(NR'(1));
        wait_beats(base + 1, 50);
        boot_mode = 2'd0;
        model_run('1);
        wait_drain(200);

        // Random rounds.
        for (int r = 0; r < 30; r++) begin
            ready_mode = 2;
            gap_en = 1'b1;
            any = 1'b0;
            for (int i = 0; i < NR; i++) begin
                nb = $urandom_range(0, 2);
                for (int j = 0; j < nb; j++) begin
                    add_burst(i, $urandom_range(1, 6), AW'({$urandom, $urandom}), 1'b1);
                    any = 1'b1;
                end
            end
            if (!any) add_burst($urandom_range(0, NR - 1), $urandom_range(1, 6), AW'({$urandom, $urandom}), 1'b1);
            model_run('1);
            wait_drain(800);
            @(negedge clk); #1;
            chk("round_err", 128'(err), 128'(model_err));
            if (model_err) begin
                clear_err();
                model_err = 1'b0;
            end
        end
        ready_mode = 0;
        gap_en = 1'b0;
        @(negedge clk); #1;

        // Runaway burst: 6 beats without last.
        base = beats_seen;
        add_burst(1, 6, AW'(48'h4000_0000), 1'b0);
        model_run('1);
        wait_beats(base + 4, 50);
        ready_mode = 3;
        @(negedge clk); #1;
        chk("overflow_err_set", 128'(err), 128'(1));
        clear_err();
        chk("overflow_new_burst_busy", 128'(busy), 128'(1));
        ready_mode = 0;
        wait_beats(base + 5, 50);
        ready_mode = 3;
        @(negedge clk); #1;
        chk("second_beat_in_flight", 128'(bus.mem_valid_o), 128'(1));

        // Reset during beat 2 of the new burst.
        rst = 1'b1;
        #1;
        check_reset_outputs("midburst_reset");
        expq.delete();
        for (int i = 0; i < NR; i++) mq[i].delete();
        mptr = 0;
        model_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        @(negedge clk); #1;

        // Pointer back at 0: requester 1 must win over requester 2.
        add_burst(1, 1, AW'(48'h5000_0000), 1'b1);
        add_burst(2, 1, AW'(48'h5100_0000), 1'b1);
        model_run('1);
        wait_drain(100);
        chk("post_reset_err", 128'(err), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
